led_blink_array: RTL

Parametrised multi-channel LED pattern generator. It is the successor to the single-channel 1 Hz blinker. A shared prescaler produces a millisecond-scale tick, and each channel runs its own mode and half-period. Channels are reconfigured at runtime through a valid/ready write port. The block sits between board-level control logic and the LED pins.

---
 rtl/led_pkg.sv | 30 +++
 rtl/led_tick_gen.sv | 29 ++
 rtl/led_blink_array.sv | 135 +++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the multi-channel LED pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PULSE = 2'd3
  } led_mode_e;

  localparam int unsigned STEP_W = 2;

  // Channel 0 keeps the legacy 1 Hz blink out of reset; the rest start dark.
  localparam led_mode_e RST_MODE_CH0   = LED_BLINK;
  localparam led_mode_e RST_MODE_OTHER = LED_OFF;

  function automatic logic mode_raw(input led_mode_e mode, input logic [STEP_W-1:0] step);
    logic r;
    r = 1'b0;
    unique case (mode)
      LED_OFF:   r = 1'b0;
      LED_ON:    r = 1'b1;
      LED_BLINK: r = step[0];
      LED_PULSE: r = (step == '0);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: one-cycle tick every CLK_HZ/TICK_HZ clocks.
module led_tick_gen #(
  parameter int unsigned CLK_HZ  = 125_000_000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_btn,
  output logic tick
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst_btn) begin
      cnt_q <= '0;
    end else if (cnt_q == TERM) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/led_blink_array.sv
// Multi-channel LED pattern generator with a valid/ready config port.
// Optional global PWM dimming when LED_PWM_EN is defined.
module led_blink_array
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 125_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned HP_W    = 16
) (
  input  logic            clk,
  input  logic            rst_btn,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [3:0]      cfg_ch,
  input  logic [1:0]      cfg_mode,
  input  logic [HP_W-1:0] cfg_half,
`ifdef LED_PWM_EN
  input  logic [7:0]      brightness,
`endif
  output logic [N_CH-1:0] LED
);

  localparam logic [HP_W-1:0] RST_HALF = HP_W'(TICK_HZ / 2);

  logic tick;

  led_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk    (clk),
    .rst_btn(rst_btn),
    .tick   (tick)
  );

  // Accepted write is held one cycle, then applied to the addressed channel.
  logic            ready_q;
  logic            pend_q;
  logic [3:0]      pend_ch_q;
  led_mode_e       pend_mode_q;
  logic [HP_W-1:0] pend_half_q;
  logic            accept;

  assign accept    = cfg_valid && ready_q;
  assign cfg_ready = ready_q;

  always_ff @(posedge clk) begin
    if (rst_btn) begin
      ready_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_ch_q   <= '0;
      pend_mode_q <= LED_OFF;
      pend_half_q <= '0;
    end else begin
      ready_q <= !accept;
      pend_q  <= accept;
      if (accept) begin
        pend_ch_q   <= cfg_ch;
        pend_mode_q <= led_mode_e'(cfg_mode);
        pend_half_q <= cfg_half;
      end
    end
  end

  logic [N_CH-1:0] raw;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam led_mode_e RST_MODE = (i == 0) ? RST_MODE_CH0 : RST_MODE_OTHER;

    led_mode_e         mode_q;
    logic [HP_W-1:0]   half_q;
    logic [HP_W-1:0]   cnt_q;
    logic [STEP_W-1:0] step_q;
    logic [HP_W-1:0]   term;
    logic              load;

    // A half-period of zero behaves as one.
    assign term = (half_q == '0) ? '0 : half_q - HP_W'(1);
    assign load = pend_q && (pend_ch_q == 4'(i));

    always_ff @(posedge clk) begin
      if (rst_btn) begin
        mode_q <= RST_MODE;
        half_q <= RST_HALF;
        cnt_q  <= '0;
        step_q <= '0;
      end else if (load) begin
        mode_q <= pend_mode_q;
        half_q <= pend_half_q;
        cnt_q  <= '0;
        step_q <= '0;
      end else if (tick) begin
        if (cnt_q == term) begin
          cnt_q  <= '0;
          step_q <= step_q + STEP_W'(1);
        end else begin
          cnt_q <= cnt_q + HP_W'(1);
        end
      end
    end

    assign raw[i] = mode_raw(mode_q, step_q);
  end

  logic [N_CH-1:0] led_d;
  logic [N_CH-1:0] led_q;

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_btn) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  assign led_d = raw & {N_CH{pwm_cnt_q < brightness}};
`else
  assign led_d = raw;
`endif

  always_ff @(posedge clk) begin
    if (rst_btn) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign LED = led_q;

endmodule
